// File: rtl/obi_mem_slv_rsp.sv
// OBI memory responder: word-addressed memory committed at the accept edge, with
// in-order responses held in a small FIFO that enforces a minimum response latency.
module obi_mem_slv_rsp #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 1,
  parameter int MEM_DEPTH       = 256,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RSP_LATENCY     = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  output logic                    gnt,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [ID_WIDTH-1:0]     aid,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [ID_WIDTH-1:0]     rid,
  output logic                    exokay
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int AGE_W = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;

  function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (a == {AGE_W{1'b1}}) ? a : a + AGE_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [MAX_OUTSTANDING];
  logic                  err_q  [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]   rid_q  [MAX_OUTSTANDING];
  logic [AGE_W-1:0]      age_q  [MAX_OUTSTANDING];

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic             ready_q;
  logic             accept, pop, oor, head_ok;
  logic [IDX_W-1:0] idx;
  logic [DATA_WIDTH-1:0] push_data;
  logic             unused_ok;

  assign idx       = addr[OFF+IDX_W-1:OFF];
  assign unused_ok = ^addr[OFF-1:0];

  // Any set address bit above the memory index makes the access out of range.
  if (ADDR_WIDTH > OFF + IDX_W) begin : g_oor
    assign oor = |addr[ADDR_WIDTH-1:OFF+IDX_W];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  if (RSP_LATENCY > 1) begin : g_lat
    assign head_ok = (age_q[rd_ptr_q] >= AGE_W'(RSP_LATENCY - 1));
  end else begin : g_nolat
    assign head_ok = 1'b1;
  end

  assign gnt       = ready_q & (count_q < CNT_W'(MAX_OUTSTANDING));
  assign accept    = req & gnt;
  assign rvalid    = (count_q != '0) & head_ok;
  assign pop       = rvalid & rready;
  assign push_data = (we | oor) ? '0 : mem_q[idx];

  assign rdata  = rvalid ? data_q[rd_ptr_q] : '0;
  assign err    = rvalid ? err_q[rd_ptr_q]  : 1'b0;
  assign rid    = rvalid ? rid_q[rd_ptr_q]  : '0;
  assign exokay = 1'b0;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (accept) wr_ptr_d = nxt_ptr(wr_ptr_q);
    if (pop)    rd_ptr_d = nxt_ptr(rd_ptr_q);
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: flushed by reset, so pending responses are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ready_q  <= 1'b1;
    end
  end

  // Response payload and ages; only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (accept && (wr_ptr_q == PTR_W'(i))) age_q[i] <= '0;
      else                                   age_q[i] <= sat_inc(age_q[i]);
    end
    if (accept) begin
      data_q[wr_ptr_q] <= push_data;
      err_q[wr_ptr_q]  <= oor;
      rid_q[wr_ptr_q]  <= aid;
    end
  end

  // Memory array survives reset; writes commit at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && we && !oor) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_obi_mem_slv_rsp.sv
// Scoreboard bench for obi_mem_slv_rsp: a driver predicts each response from a
// reference memory at accept time; a monitor checks every response handshake.
module tb_obi_mem_slv_rsp;
  logic        clk = 1'b0, reset_n = 1'b1, req = 1'b0, we = 1'b0, rready = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic [0:0]  aid = '0;
  logic        gnt, rvalid, err, exokay;
  logic [31:0] rdata;
  logic [0:0]  rid;

  obi_mem_slv_rsp dut (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .addr(addr), .we(we),
    .be(be), .wdata(wdata), .aid(aid), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .err(err), .rid(rid), .exokay(exokay)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic [0:0]  id;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [256];
  int checks = 0, errors = 0, cyc = 0, mode = 1, stalls = 0, hs = 0, last_hs_cyc = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (mode)
      0:       rready = 1'b0;
      1:       rready = 1'b1;
      default: rready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic        stalled = 1'b0;
  logic [31:0] s_d;
  logic        s_e;
  logic [0:0]  s_id;
  exp_t        m_e;

  always @(negedge clk) begin
    if (!reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_rvalid", 64'(rvalid), 64'(1'b1));
        chk("hold_payload", 64'({rdata, err, rid}), 64'({s_d, s_e, s_id}));
      end
      stalled = 1'b0;
      if (rvalid) begin
        if (rready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual rdata=%0h rid=%0h required none", rdata, rid);
          end else begin
            m_e = sb.pop_front();
            chk("rsp", 64'({rdata, err, rid, exokay}), 64'({m_e.d, m_e.e, m_e.id, 1'b0}));
            hs++;
            last_hs_cyc = cyc;
          end
        end else begin
          stalled = 1'b1;
          s_d = rdata;
          s_e = err;
          s_id = rid;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [0:0] id);
    int   n = 0;
    exp_t e;
    logic [7:0] ix;
    req = 1'b1; we = w; addr = a; be = b; wdata = d; aid = id;
    while (!gnt && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n > 0) stalls++;
    if (!gnt) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual gnt=0 required gnt=1 addr=%0h", a);
      req = 1'b0;
      return;
    end
    ix   = a[9:2];
    e.id = id;
    e.e  = (a[31:10] != 22'd0);
    e.d  = '0;
    if (!e.e) begin
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[ix][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.d = ref_mem[ix];
      end
    end
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    mode = 1;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0, a;
    int s0, h0, c0;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_gnt", 64'(gnt), 64'(1'b0));
    chk("reset_outs", 64'({rvalid, rdata, err, rid, exokay}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("gnt_after_reset", 64'(gnt), 64'(1'b1));

    for (int i = 0; i < 256; i++)
      issue(1'b1, 32'(i) << 2, 4'hF, $urandom, 1'($urandom_range(0, 1)));
    drain();

    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
    chk("rd_latency_l1", 64'(rvalid), 64'(1'b1));
    chk("rd_data", 64'({rdata, err, rid}), 64'({32'hDEADBEEF, 1'b0, 1'b0}));
    drain();

    issue(1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0);
    issue(1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 1'b1);
    issue(1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
    chk("be_merge", 64'(rdata), 64'(32'h11BB33DD));
    drain();

    w0 = ref_mem[0];
    issue(1'b1, 32'h400, 4'hF, $urandom, 1'b1);
    issue(1'b0, 32'h400, 4'hF, 32'h0, 1'b0);
    chk("oor_rd", 64'({err, rdata}), 64'({1'b1, 32'h0}));
    issue(1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
    chk("word0_intact", 64'(rdata), 64'(w0));
    drain();

    mode = 0;
    @(negedge clk);
    @(negedge clk);
    issue(1'b0, 32'h40, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 32'h44, 4'hF, 32'h0, 1'b1);
    chk("gnt_full", 64'(gnt), 64'(1'b0));
    fork
      issue(1'b0, 32'h48, 4'hF, 32'h0, 1'b0);
    join_none
    repeat (3) @(negedge clk);
    mode = 1;
    @(negedge clk);
    chk("gnt_before_pop", 64'(gnt), 64'(1'b0));
    @(negedge clk);
    chk("gnt_after_pop", 64'(gnt), 64'(1'b1));
    wait fork;
    drain();

    s0 = stalls; h0 = hs; c0 = cyc;
    for (int i = 0; i < 16; i++)
      issue(1'b0, 32'($urandom_range(0, 255)) << 2, 4'hF, 32'h0, 1'($urandom_range(0, 1)));
    drain();
    chk("stream_no_stall", 64'(stalls), 64'(s0));
    chk("stream_count", 64'(hs - h0), 64'(16));
    chk("stream_cycles", 64'(last_hs_cyc - c0), 64'(16));

    mode = 2;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 9) != 0) a[31:10] = '0;
      issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)));
    end
    drain();

    mode = 0;
    @(negedge clk);
    @(negedge clk);
    issue(1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 1'b0);
    issue(1'b0, 32'h34, 4'hF, 32'h0, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_rvalid", 64'(rvalid), 64'(1'b0));
    chk("async_rst_gnt", 64'(gnt), 64'(1'b0));
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release_gnt", 64'(gnt), 64'(1'b1));
    mode = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", 64'(rvalid), 64'(1'b0));
    end
    issue(1'b0, 32'h30, 4'hF, 32'h0, 1'b1);
    chk("committed_write", 64'({rdata, err, rid}), 64'({32'hCAFEF00D, 1'b0, 1'b1}));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
